// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter that is the single writer of a shared WIDTH-bit storage word.
// One requester can hold ownership with i_lock. All outputs come straight from flops.
module dff_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*WIDTH-1:0]    i_data,
    input  logic [NREQ-1:0]          i_lock,
    output logic [NREQ-1:0]          o_ack,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(NREQ)-1:0]  o_owner,
    output logic                     o_locked
);
    localparam int OW = $clog2(NREQ);
    localparam logic [0:0] ST_OPEN   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]      state, state_nxt;
    logic [OW-1:0]   ptr;
    logic [NREQ-1:0] elig;
    logic            found;
    logic [OW-1:0]   winner;
    logic            do_write;
    logic [OW-1:0]   wsel;
    logic [OW:0]     sum;
    logic [OW-1:0]   idx;

    // A requester whose ack is high this cycle is masked so one handshake gives one write.
    assign elig = i_req & ~o_ack;

    always_comb begin
        found  = 1'b0;
        winner = ptr;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (OW+1)'(i);
            if (sum >= (OW+1)'(NREQ))
                sum = sum - (OW+1)'(NREQ);
            idx = sum[OW-1:0];
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        do_write  = 1'b0;
        wsel      = winner;
        state_nxt = state;
        if (state == ST_OPEN) begin
            if (found) begin
                do_write  = 1'b1;
                state_nxt = i_lock[winner] ? ST_LOCKED : ST_OPEN;
            end
        end else begin
            // Locked: only the owner may write; it releases by dropping req once its ack is gone.
            wsel = o_owner;
            if (elig[o_owner]) begin
                do_write  = 1'b1;
                state_nxt = i_lock[o_owner] ? ST_LOCKED : ST_OPEN;
            end else if (!i_req[o_owner] && !o_ack[o_owner]) begin
                state_nxt = ST_OPEN;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_OPEN;
            ptr     <= '0;
            o_ack   <= '0;
            o_data  <= '0;
            o_owner <= '0;
        end else begin
            state <= state_nxt;
            o_ack <= '0;
            if (do_write) begin
                o_ack   <= NREQ'(1) << wsel;
                o_data  <= i_data[wsel*WIDTH +: WIDTH];
                o_owner <= wsel;
                ptr     <= (wsel == OW'(NREQ-1)) ? '0 : wsel + 1'b1;
            end
        end
    end

    assign o_locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Bench for dff_write_arbiter: directed literal checks plus random protocol-compliant
// requesters compared every cycle against an integer-level model of the arbitration rules.
module tb_dff_write_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int OW    = $clog2(NREQ);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ-1:0]         lock = '0;
    logic [NREQ*WIDTH-1:0]   data = '0;
    logic [NREQ-1:0]         ack;
    logic [WIDTH-1:0]        q;
    logic [OW-1:0]           owner;
    logic                    locked;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    // Reference state: ack is an index (-1 means none), everything else plain ints.
    logic [WIDTH-1:0] m_data;
    int m_ack, m_owner, m_ptr;
    bit m_locked;

    always #5 clk = ~clk;

    dff_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data), .i_lock(lock),
        .o_ack(ack), .o_data(q), .o_owner(owner), .o_locked(locked)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int a);
        onehot = '0;
        if (a >= 0) onehot[a] = 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        int k;
        if (!rst_n) begin
            m_data = '0; m_ack = -1; m_owner = 0; m_ptr = 0; m_locked = 0;
        end else begin
            w = -1;
            if (m_locked) begin
                if (req[m_owner] && m_ack != m_owner) w = m_owner;
                else if (!req[m_owner] && m_ack != m_owner) m_locked = 0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    k = (m_ptr + i) % NREQ;
                    if (w < 0 && req[k] && m_ack != k) w = k;
                end
            end
            if (w >= 0) begin
                m_data   = data[w*WIDTH +: WIDTH];
                m_ack    = w;
                m_owner  = w;
                m_ptr    = (w + 1) % NREQ;
                m_locked = lock[w];
            end else begin
                m_ack = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_data",   32'(q),      32'(m_data));
            chk("cyc_ack",    32'(ack),    32'(onehot(m_ack)));
            chk("cyc_owner",  32'(owner),  32'(m_owner));
            chk("cyc_locked", 32'(locked), 32'(m_locked));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic set_d(input int k, input logic [WIDTH-1:0] v);
        data[k*WIDTH +: WIDTH] = v;
    endtask

    bit chg[NREQ];

    initial begin
        #12 rst_n = 1'b1;
        started = 1;

        // Write something, then reset asynchronously between edges.
        req = 4'b0010; set_d(1, 8'h3C);
        step(); chk("pre_ack", 32'(ack), 32'h2); chk("pre_data", 32'(q), 32'h3C);
        req = '0;
        #2 rst_n = 1'b0;
        #1 chk("rst_data", 32'(q), 32'h0); chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0); chk("rst_owner", 32'(owner), 32'h0);
        rst_n = 1'b1;
        req = 4'b0100; set_d(2, 8'hA5);
        step(); chk("a5_data", 32'(q), 32'hA5); chk("a5_ack", 32'(ack), 32'h4);
        chk("a5_owner", 32'(owner), 32'h2);
        req = '0; step();

        // Round robin from ptr 0.
        pulse_reset();
        for (int k = 0; k < NREQ; k++) set_d(k, 8'(8'h10 + k));
        req = 4'b1111;
        for (int c = 0; c < NREQ; c++) begin
            step();
            chk("rr_ack", 32'(ack), 32'(1 << c));
            chk("rr_data", 32'(q), 32'(8'h10 + c));
            req[c] = 1'b0;
        end

        // Pointer wrap after grant to 3.
        req = 4'b1001; set_d(0, 8'hC0); set_d(3, 8'hC3);
        step(); chk("wrap_first", 32'(ack), 32'h1); req[0] = 1'b0;
        step(); chk("wrap_second", 32'(ack), 32'h8); chk("wrap_data", 32'(q), 32'hC3);
        req[3] = 1'b0;

        // Ack masking: held request gets its second write two edges later.
        req = 4'b0010; set_d(1, 8'h55);
        step(); chk("mask_ack1", 32'(ack), 32'h2);
        step(); chk("mask_gap", 32'(ack), 32'h0);
        set_d(1, 8'h66);
        step(); chk("mask_ack2", 32'(ack), 32'h2); chk("mask_data2", 32'(q), 32'h66);
        req = '0; step();

        // Lock burst while requester 0 waits.
        pulse_reset();
        req = 4'b0100; lock = 4'b0100; set_d(2, 8'h11); set_d(0, 8'h77);
        step(); chk("lk_ack", 32'(ack), 32'h4); chk("lk_locked", 32'(locked), 32'h1);
        req[0] = 1'b1;
        step(); chk("lk_wait_ack", 32'(ack), 32'h0); chk("lk_wait_locked", 32'(locked), 32'h1);
        set_d(2, 8'h22);
        step(); chk("lk_22", 32'(q), 32'h22); chk("lk_22_ack", 32'(ack), 32'h4);
        step(); chk("lk_gap2", 32'(ack), 32'h0);
        set_d(2, 8'h33); lock[2] = 1'b0;
        step(); chk("lk_33", 32'(q), 32'h33); chk("lk_unlocked", 32'(locked), 32'h0);
        req[2] = 1'b0;
        step(); chk("lk_r0_ack", 32'(ack), 32'h1); chk("lk_r0_data", 32'(q), 32'h77);
        req = '0; lock = '0; step();

        // Release by dropping req.
        pulse_reset();
        req = 4'b0100; lock = 4'b0100; set_d(2, 8'h44);
        step(); chk("rel_locked", 32'(locked), 32'h1);
        req = '0;
        step(); chk("rel_still", 32'(locked), 32'h1);
        step(); chk("rel_open", 32'(locked), 32'h0); chk("rel_data", 32'(q), 32'h44);
        chk("rel_ack", 32'(ack), 32'h0);

        // Reset while locked.
        req = 4'b0100; set_d(2, 8'h99);
        step(); chk("rl_locked", 32'(locked), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("rl_unlocked", 32'(locked), 32'h0); chk("rl_data", 32'(q), 32'h0);
        rst_n = 1'b1; req = '0; lock = '0;
        step();

        // Random protocol-compliant traffic.
        for (int k = 0; k < NREQ; k++) chg[k] = 0;
        repeat (3000) begin
            step();
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #1 chk("rnd_rst_locked", 32'(locked), 32'h0);
                chk("rnd_rst_ack", 32'(ack), 32'h0);
                rst_n = 1'b1; req = '0; lock = '0;
                for (int k = 0; k < NREQ; k++) chg[k] = 0;
                continue;
            end
            for (int k = 0; k < NREQ; k++) begin
                if (chg[k]) begin
                    chg[k] = 0;
                    if ($urandom_range(0, 2) == 0) req[k] = 1'b0;
                    else begin
                        set_d(k, WIDTH'($urandom));
                        lock[k] = ($urandom_range(0, 3) == 0);
                    end
                end else if (m_ack == k) begin
                    chg[k] = 1;
                end else if (!req[k] && $urandom_range(0, 3) == 0) begin
                    req[k] = 1'b1;
                    set_d(k, WIDTH'($urandom));
                    lock[k] = ($urandom_range(0, 3) == 0);
                end
            end
        end
        req = '0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
